line_rasterizer: RTL
====================

LINE_RASTERIZER -- requirements
Module: line_rasterizer

Interface
REQ-001 SHALL have parameter H_RES, default 640, meaning framebuffer width in pixels and address row stride.
REQ-002 SHALL have parameter V_RES, default 480, meaning framebuffer height in pixels.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  1  line request present.
REQ-007 req_ready  output  1  rasterizer can accept a request.
REQ-008 x0, x1  input  10 each  start and end column, unsigned.
REQ-009 y0, y1  input  9 each  start and end row, unsigned.
REQ-010 color  input  4  intensity for the line.
REQ-011 stall  input  1  framebuffer write path not accepting; freezes the rasterizer.
REQ-012 w_addr  output  19  framebuffer write address, y*H_RES+x.
REQ-013 en_w  output  1  write strobe for w_addr/color_in.
REQ-014 color_in  output  4  write data, registered copy of color.
REQ-015 lineDone  output  1  one-cycle pulse when the last pixel of a line has been issued.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement the FSM IDLE -> SETUP -> DRAW -> DONE -> IDLE.
REQ-018 req_ready SHALL be 1 only in IDLE, and a request is accepted on the edge where req_valid&&req_ready.
REQ-019 On accept, the block SHALL latch x0, y0, x1, y1 and color, then go to SETUP.
REQ-020 In SETUP (one cycle), the block SHALL compute:
- dx=|x1-x0|, dy=-|y1-y0|
- sx=+1 if x0<x1 else -1; sy=+1 if y0<y1 else -1
- err=dx+dy, signed 12 bits
- current point (x,y)=(x0,y0)
REQ-021 In DRAW with stall=0, the block SHALL issue one pixel per cycle:
- w_addr=y*H_RES+x, en_w=1, color_in=latched color, all registered outputs.
- If (x,y)==(x1,y1), go to DONE.
- Otherwise, with e2=2*err: if e2>=dy then err+=dy and x+=sx; if e2<=dx then err+=dx and y+=sy. Both updates use the pre-update err.
REQ-022 In DRAW with stall=1, x, y, err, state, w_addr and color_in SHALL hold, and en_w SHALL be 0.
REQ-023 Pixels per line SHALL be max(|x1-x0|,|y1-y0|)+1, endpoints inclusive, issued in order from (x0,y0).
REQ-024 Clipping: a pixel with x>=H_RES or y>=V_RES SHALL be stepped with en_w=0, and w_addr is don't-care for that cycle.
REQ-025 lineDone SHALL be asserted for exactly one cycle in DONE; en_w SHALL be 0 in DONE.
REQ-026 Latency SHALL be: accept edge -> first en_w 2 cycles (SETUP, then first DRAW output); last en_w -> lineDone 1 cycle.
REQ-027 Degenerate line (x0==x1, y0==y1) SHALL produce exactly one pixel, then lineDone.
REQ-028 Requests arriving while busy SHALL NOT be accepted and SHALL wait via req_ready=0; no queueing is performed.
REQ-029 stall SHALL be ignored in IDLE, SETUP and DONE.
REQ-030 Internal arithmetic SHALL NOT wrap: x/y use 11-bit signed internally; w_addr uses 19 bits, max 479*640+639=307199.

Reset
REQ-031 On rst=1, asynchronously:
- state=IDLE
- req_ready=1 (combinational from state)
- en_w=0, lineDone=0, busy=0
- w_addr=0, color_in=0
- internal x, y, err=0
REQ-032 Reset mid-line SHALL abort the line with no further en_w and no lineDone; the first request after deassertion is accepted normally.

Verification
REQ-033 Horizontal line (0,0)->(3,0), color 0xF -> en_w on 4 consecutive cycles, w_addr 0,1,2,3, color_in 0xF, then lineDone pulse.
REQ-034 Steep line (10,10)->(12,15) -> 6 pixels (10,10),(10,11),(11,12),(11,13),(12,14),(12,15); w_addr 6410,7050,7691,8331,8972,9612.
REQ-035 Reverse diagonal (5,5)->(2,2) with stall=1 for 3 cycles after the 2nd pixel -> addresses 3205,2564,1923,1282; en_w=0 during stall, no pixel duplicated or lost.
REQ-036 Clipped line (638,0)->(641,0) -> en_w only for x=638,639 (addr 638,639); 4 DRAW cycles; lineDone still pulses.
REQ-037 Point (7,3)->(7,3) -> single en_w at addr 1927, lineDone next cycle; a back-to-back second request is held off by req_ready=0 until IDLE.
REQ-038 rst asserted on the 2nd pixel of (0,0)->(100,0) -> en_w and busy fall immediately, no lineDone; a new request (1,1)->(1,1) after release yields addr 641.

Source files
------------

// File: rtl/line_rasterizer_if.sv
// Request, framebuffer-write and status signals of line_rasterizer.
// Master drives requests and stall; slave is the rasterizer.
interface line_rasterizer_if;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  x0;
  logic [9:0]  x1;
  logic [8:0]  y0;
  logic [8:0]  y1;
  logic [3:0]  color;
  logic        stall;
  logic [18:0] w_addr;
  logic        en_w;
  logic [3:0]  color_in;
  logic        lineDone;
  logic        busy;

  modport master (
    output req_valid, x0, x1, y0, y1, color, stall,
    input  req_ready, w_addr, en_w, color_in, lineDone, busy
  );

  modport slave (
    input  req_valid, x0, x1, y0, y1, color, stall,
    output req_ready, w_addr, en_w, color_in, lineDone, busy
  );
endinterface

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: one framebuffer write per DRAW cycle, pixels outside H_RES x V_RES suppressed.
// Accept -> first write after SETUP; stall freezes DRAW with en_w low; req_ready only in IDLE.
module line_rasterizer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input logic              clk,
  input logic              rst,
  line_rasterizer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

  localparam logic [18:0]        LP_STRIDE = 19'(H_RES);
  localparam logic signed [10:0] LP_XMAX   = 11'(H_RES);
  localparam logic signed [10:0] LP_YMAX   = 11'(V_RES);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [9:0]         r_x0, r_x1;
  logic [8:0]         r_y0, r_y1;
  logic [3:0]         r_color;
  logic signed [10:0] r_x, r_y;
  logic signed [11:0] r_err, r_dx, r_dy;
  logic               r_sx_neg, r_sy_neg;
  logic [18:0]        r_addr;
  logic               r_inb;

  logic               w_accept, w_at_end, w_step;
  logic [9:0]         w_adx;
  logic [8:0]         w_ady;
  logic signed [12:0] w_e2, w_dx13, w_dy13;
  logic               w_mv_x, w_mv_y;
  logic signed [10:0] w_sx, w_sy, w_nx, w_ny, w_px, w_py;
  logic signed [11:0] w_nerr;
  logic [18:0]        w_naddr;
  logic               w_ninb;

  assign w_accept = bus.req_valid && (r_state == S_IDLE);
  assign w_at_end = (r_x == $signed({1'b0, r_x1})) && (r_y == $signed({2'b00, r_y1}));
  assign w_step   = (r_state == S_DRAW) && !bus.stall && !w_at_end;

  assign w_adx = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
  assign w_ady = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);

  // Both step decisions compare against the error term as it was before this step.
  assign w_e2   = {r_err, 1'b0};
  assign w_dx13 = {r_dx[11], r_dx};
  assign w_dy13 = {r_dy[11], r_dy};
  assign w_mv_x = (w_e2 >= w_dy13);
  assign w_mv_y = (w_e2 <= w_dx13);
  assign w_sx   = r_sx_neg ? -11'sd1 : 11'sd1;
  assign w_sy   = r_sy_neg ? -11'sd1 : 11'sd1;
  assign w_nx   = w_mv_x ? (r_x + w_sx) : r_x;
  assign w_ny   = w_mv_y ? (r_y + w_sy) : r_y;
  assign w_nerr = r_err + (w_mv_x ? r_dy : 12'sd0) + (w_mv_y ? r_dx : 12'sd0);

  // Address and visibility are registered alongside the point they describe.
  assign w_px    = (r_state == S_SETUP) ? $signed({1'b0, r_x0}) : w_nx;
  assign w_py    = (r_state == S_SETUP) ? $signed({2'b00, r_y0}) : w_ny;
  assign w_naddr = 19'(w_py[8:0]) * LP_STRIDE + 19'(w_px[9:0]);
  assign w_ninb  = (w_px < LP_XMAX) && (w_py < LP_YMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.req_valid) w_state_nxt = S_SETUP;
      S_SETUP: w_state_nxt = S_DRAW;
      S_DRAW:  if (!bus.stall && w_at_end) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (r_state == S_IDLE);
    bus.busy      = (r_state != S_IDLE);
    bus.lineDone  = (r_state == S_DONE);
    bus.en_w      = (r_state == S_DRAW) && !bus.stall && r_inb;
  end

  assign bus.w_addr   = r_addr;
  assign bus.color_in = r_color;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x0     <= '0;
      r_x1     <= '0;
      r_y0     <= '0;
      r_y1     <= '0;
      r_color  <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_err    <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
      r_addr   <= '0;
      r_inb    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_x0    <= bus.x0;
        r_x1    <= bus.x1;
        r_y0    <= bus.y0;
        r_y1    <= bus.y1;
        r_color <= bus.color;
      end
      if (r_state == S_SETUP) begin
        r_dx     <= $signed({2'b00, w_adx});
        r_dy     <= -$signed({3'b000, w_ady});
        r_err    <= $signed({2'b00, w_adx}) - $signed({3'b000, w_ady});
        r_sx_neg <= !(r_x0 < r_x1);
        r_sy_neg <= !(r_y0 < r_y1);
        r_x      <= w_px;
        r_y      <= w_py;
        r_addr   <= w_naddr;
        r_inb    <= w_ninb;
      end else if (w_step) begin
        r_x    <= w_nx;
        r_y    <= w_ny;
        r_err  <= w_nerr;
        r_addr <= w_naddr;
        r_inb  <= w_ninb;
      end
    end
  end

endmodule
